// File: rtl/pipe_skid_stage.sv
// Two-slot pipeline skid buffer with registered in_ready and a saturating stall counter.
// MAIN drives the outputs. SKID catches the one entry accepted while MAIN is blocked.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [1:0]        occ_q;
  logic [CNT_W-1:0]  stall_q;
  logic              xfer_in;
  logic              xfer_out;

  assign xfer_in  = in_valid & in_ready_q;
  assign xfer_out = out_valid_q & out_ready;

  // Control bits in a slot are cleared whenever that slot becomes invalid.
  // This keeps out_ctrl at zero without any gating on the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_ctrl   <= '0;
      main_data   <= '0;
      skid_ctrl   <= '0;
      skid_data   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else if (flush) begin
      state       <= EMPTY;
      main_ctrl   <= '0;
      skid_ctrl   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            state       <= ONE;
            main_ctrl   <= in_ctrl;
            main_data   <= in_data;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (xfer_in) begin
            state      <= FULL;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            in_ready_q <= 1'b0;
            occ_q      <= 2'd2;
          end else if (xfer_out) begin
            state       <= EMPTY;
            main_ctrl   <= '0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state      <= ONE;
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_ctrl  <= '0;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          main_ctrl   <= '0;
          skid_ctrl   <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

  // Flush leaves this counter alone, so stalls are still counted across a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. A queue model (capacity 2) is checked every cycle,
// and directed scenarios are pinned with literal expectations.
module tb_pipe_skid_stage;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  logic              d2_in_ready, d2_out_valid;
  logic [CTRL_W-1:0] d2_out_ctrl;
  logic [DATA_W-1:0] d2_out_data;
  logic [1:0]        d2_occupancy;
  logic [1:0]        d2_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [CTRL_W+DATA_W-1:0] mq[$];
  int m_stall, m_stall2;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_ctrl(d2_out_ctrl), .out_data(d2_out_data), .occupancy(d2_occupancy),
    .stall_cnt(d2_stall_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model works only at the level of a queue: in_ready means fewer than 2 entries
  // were held at the start of the cycle, and the outputs show the oldest entry.
  task automatic model_edge();
    bit in_ok, out_ok;
    if (!rst_n) begin
      mq.delete();
      m_stall  = 0;
      m_stall2 = 0;
    end else begin
      if (mq.size() > 0 && !out_ready) begin
        if (m_stall < (1 << CNT_W) - 1) m_stall++;
        if (m_stall2 < 3) m_stall2++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        in_ok  = in_valid && (mq.size() < 2);
        out_ok = (mq.size() > 0) && out_ready;
        if (out_ok) void'(mq.pop_front());
        if (in_ok) mq.push_back({in_ctrl, in_data});
      end
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (mq.size() > 0);
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("occupancy", occupancy, mq.size());
    chk("out_ctrl", out_ctrl, v ? mq[0][CTRL_W+DATA_W-1:DATA_W] : '0);
    if (v) chk("out_data", out_data, mq[0][DATA_W-1:0]);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("stall_cnt_w2", d2_stall_cnt, m_stall2);
    chk("d2_out_valid", d2_out_valid, v);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive(1, 8'hFF, 32'hDEAD_BEEF, 1);
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;

    // Streaming 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'h10 + 8'(i), DATA_W'(i), 1);
      cyc();
      chk("stream_data", out_data, i);
      chk("stream_occ", occupancy, 1);
    end
    drive(0, 0, 0, 1);
    cyc();
    chk("stream_stall", stall_cnt, 0);

    // Backpressure: A, B, then C offered while full
    drive(1, 8'h01, 32'hA, 0); cyc();
    drive(1, 8'h02, 32'hB, 0); cyc();
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_stall1", stall_cnt, 1);
    drive(1, 8'h03, 32'hC, 0); cyc();
    chk("bp_stall2", stall_cnt, 2);
    chk("bp_head", out_data, 32'hA);
    drive(0, 0, 0, 1); cyc();
    chk("bp_second", out_data, 32'hB);
    chk("bp_second_ctrl", out_ctrl, 8'h02);
    cyc();
    chk("bp_drained", out_valid, 0);

    // Flush while FULL with an entry offered
    drive(1, 8'h21, 32'h21, 0); cyc();
    drive(1, 8'h22, 32'h22, 0); cyc();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1; drive(1, 8'h23, 32'h23, 1); cyc();
    flush = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_ctrl", out_ctrl, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    drive(0, 0, 0, 1); cyc(); cyc();
    chk("fl_still_empty", out_valid, 0);

    // Reset while FULL
    drive(1, 8'h31, 32'h31, 0); cyc();
    drive(1, 8'h32, 32'h32, 0); cyc();
    rst_n = 1'b0; drive(1, 8'h33, 32'h33, 1); cyc();
    rst_n = 1'b1;
    chk("rr_out_valid", out_valid, 0);
    chk("rr_out_data", out_data, 0);
    chk("rr_occ", occupancy, 0);
    chk("rr_in_ready", in_ready, 1);
    chk("rr_stall", stall_cnt, 0);
    drive(1, 8'h55, 32'h55, 1); cyc();
    chk("rr_first", out_data, 32'h55);
    chk("rr_first_valid", out_valid, 1);
    drive(0, 0, 0, 1); cyc();

    // Saturation on the CNT_W=2 instance: 1,2,3,3,3,3
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    drive(1, 8'h44, 32'h44, 0); cyc();
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("sat_w2", d2_stall_cnt, (i < 3) ? i : 3);
      chk("sat_w16", stall_cnt, i);
    end
    drive(0, 0, 0, 1); cyc(); cyc();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_ctrl   = CTRL_W'($urandom_range(1, 255));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 99) == 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
